kalk_sterownik: RTL

KALK_STEROWNIK -- requirements
Module: kalk_sterownik

---
 rtl/kalk_sterownik.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/kalk_sterownik.sv
`default_nettype none
// ============================================================================
//  Module      : kalk_sterownik
//  Description : Push-button calculator controller. Synchronises four
//                active-low keys, runs add / subtract / shift-add multiply
//                on two 5-bit operands, converts the result to BCD by
//                iterative double-dabble and drives four digit outputs
//                plus a binary LED copy of the result magnitude.
//  Revision    : 1.0 - initial release
// ============================================================================
module kalk_sterownik #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [3:0] cyfra0,
   output logic [3:0] cyfra1,
   output logic [3:0] cyfra2,
   output logic [3:0] cyfra3,
   output logic       busy,
   output logic       done,
   output logic [9:0] LEDR
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [3:0] MINUS  = 4'd10;

   // key synchroniser chain and falling-edge detection
   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] key_prev;
   logic [3:0] ev;

   state_t     state;
   logic [1:0] op;
   logic [4:0] a_q;
   logic [4:0] b_q;
   logic       neg;
   logic [9:0] mcand;
   logic [4:0] mplier;
   logic [9:0] acc;
   logic [3:0] step;
   logic [9:0] bin;
   logic [9:0] res;
   logic [15:0] bcd;

   logic [9:0]  add_res;
   logic [4:0]  sub_mag;
   logic [9:0]  acc_next;
   logic [15:0] bcd_adj;
   logic [15:0] bcd_next;

   // shift the raw keys through the synchroniser; reset means "released"
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'hF;
         key_prev <= 4'hF;
      end else begin
         sync_q[0] <= KEY;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         key_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign ev = key_prev & ~sync_q[SYNC_STAGES-1];

   // arithmetic for the CALC step and one double-dabble iteration
   always_comb begin
      add_res  = {5'd0, a_q} + {5'd0, b_q};
      sub_mag  = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
      acc_next = acc + (mplier[0] ? mcand : 10'd0);
      bcd_adj  = bcd;
      for (int n = 0; n < 4; n++) begin
         if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end
      bcd_next = (bcd_adj << 1) | {15'd0, bin[9]};
   end

   // main controller: operand latch, arithmetic, conversion, output load
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         op     <= OP_ADD;
         a_q    <= '0;
         b_q    <= '0;
         neg    <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         step   <= '0;
         bin    <= '0;
         res    <= '0;
         bcd    <= '0;
         cyfra0 <= '0;
         cyfra1 <= '0;
         cyfra2 <= '0;
         cyfra3 <= '0;
         LEDR   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (ev[3]) begin
         // clear wins over everything, including a same-cycle operation key
         state  <= IDLE;
         cyfra0 <= '0;
         cyfra1 <= '0;
         cyfra2 <= '0;
         cyfra3 <= '0;
         LEDR   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (|ev[2:0]) begin
                  a_q    <= SW[4:0];
                  b_q    <= SW[9:5];
                  op     <= ev[0] ? OP_ADD : (ev[1] ? OP_SUB : OP_MUL);
                  mcand  <= {5'd0, SW[9:5]};
                  mplier <= SW[4:0];
                  acc    <= '0;
                  step   <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               if (op == OP_MUL) begin
                  // one multiplier bit per cycle, five cycles in total
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  step   <= step + 4'd1;
                  if (step == 4'd4) begin
                     bin   <= acc_next;
                     res   <= acc_next;
                     neg   <= 1'b0;
                     bcd   <= '0;
                     step  <= '0;
                     state <= CONV;
                  end
               end else begin
                  bin   <= (op == OP_ADD) ? add_res : {5'd0, sub_mag};
                  res   <= (op == OP_ADD) ? add_res : {5'd0, sub_mag};
                  neg   <= (op == OP_SUB) && (a_q < b_q);
                  bcd   <= '0;
                  step  <= '0;
                  state <= CONV;
               end
            end
            CONV: begin
               bcd  <= bcd_next;
               bin  <= bin << 1;
               step <= step + 4'd1;
               if (step == 4'd9) begin
                  // final iteration: load the finished digits directly
                  cyfra0 <= bcd_next[3:0];
                  cyfra1 <= bcd_next[7:4];
                  cyfra2 <= bcd_next[11:8];
                  cyfra3 <= neg ? MINUS : bcd_next[15:12];
                  LEDR   <= res;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
